// File: rtl/dsc_pkg.sv
// dsc_pkg: shared FSM state encodings and the empty-criterion constant.
package dsc_pkg;
    typedef enum logic [1:0] {OCIOSO, BUSCA, EMITE, FIM} estado_t;
    localparam logic [31:0] CRITERIO_VAZIO = 32'hFFFF_FFFF;
endpackage

// File: rtl/busca_janela.sv
// busca_janela: matches NUM_PARALELO consecutive slots from ptr_i against min_i
// and priority-encodes the lowest matching slot index.
module busca_janela #(
    parameter int NUM_NA         = 8,
    parameter int CRITERIO_WIDTH = 5,
    parameter int NUM_PARALELO   = 4,
    parameter int PW             = 5,
    parameter int IW             = 3
) (
    input  logic [PW-1:0]                    ptr_i,
    input  logic [NUM_NA-1:0]                ativo_i,
    input  logic [NUM_NA*CRITERIO_WIDTH-1:0] criterio_i,
    input  logic [CRITERIO_WIDTH-1:0]        min_i,
    output logic                             acerto_o,
    output logic [IW-1:0]                    indice_o
);
    logic [NUM_PARALELO-1:0] hit;
    logic [PW-1:0]           slot [NUM_PARALELO];

    for (genvar g = 0; g < NUM_PARALELO; g++) begin : g_lane
        assign slot[g] = ptr_i + PW'(g);
        // Slots past the end never match, whatever the truncated index points at.
        assign hit[g] = (slot[g] < PW'(NUM_NA)) && ativo_i[slot[g][IW-1:0]] &&
                        (criterio_i[CRITERIO_WIDTH*slot[g][IW-1:0] +: CRITERIO_WIDTH] == min_i);
    end

    always_comb begin
        acerto_o = |hit;
        indice_o = '0;
        for (int j = NUM_PARALELO-1; j >= 0; j--)
            if (hit[j]) indice_o = IW'(slot[j]);
    end
endmodule

// File: rtl/selecionar_ativo.sv
// selecionar_ativo: scans active-node slots for those whose criterion equals the
// global minimum and hands them out one at a time. SELECIONAR_ATIVO_PRIMEIRO_EN: stop after first winner.
module selecionar_ativo
    import dsc_pkg::*;
#(
    parameter int NUM_NA         = 8,
    parameter int CRITERIO_WIDTH = 5,
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_PARALELO   = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             aa_atualizar_in,
    input  logic                             ca_pronto_in,
    input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
    input  logic [NUM_NA-1:0]                na_ativo_in,
    input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
    input  logic [NUM_NA*ADDR_WIDTH-1:0]     na_endereco_in,
    input  logic                             sa_ready_in,
    output logic                             sa_valid_o,
    output logic [$clog2(NUM_NA)-1:0]        sa_indice_o,
    output logic [ADDR_WIDTH-1:0]            sa_endereco_o,
    output logic                             sa_fim_o,
    output logic                             sa_vazio_o
);
    localparam int IW = $clog2(NUM_NA);
    localparam int PW = $clog2(NUM_NA + NUM_PARALELO) + 1;
    localparam logic [CRITERIO_WIDTH-1:0] VAZIO = CRITERIO_VAZIO[CRITERIO_WIDTH-1:0];

    estado_t                   estado_q;
    logic [PW-1:0]             ptr_q;
    logic [CRITERIO_WIDTH-1:0] min_q;
    logic                      pronto_q;
    logic                      valid_q, fim_q, vazio_q;
    logic [IW-1:0]             indice_q;
    logic [ADDR_WIDTH-1:0]     endereco_q;
    logic                      acerto;
    logic [IW-1:0]             acerto_idx;
    logic [ADDR_WIDTH-1:0]     endereco_sel;
    logic [PW-1:0]             ptr_avanco_d, ptr_aceite_d;

    busca_janela #(
        .NUM_NA(NUM_NA), .CRITERIO_WIDTH(CRITERIO_WIDTH),
        .NUM_PARALELO(NUM_PARALELO), .PW(PW), .IW(IW)
    ) u_janela (
        .ptr_i(ptr_q), .ativo_i(na_ativo_in), .criterio_i(na_criterio_in),
        .min_i(min_q), .acerto_o(acerto), .indice_o(acerto_idx)
    );

    assign endereco_sel = na_endereco_in[ADDR_WIDTH*acerto_idx +: ADDR_WIDTH];
    assign ptr_avanco_d = ptr_q + PW'(NUM_PARALELO);
    assign ptr_aceite_d = PW'(indice_q) + PW'(1);

    // Scan end is decided one step ahead so sa_fim_o lands in the cycle after the last window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= OCIOSO;
            ptr_q      <= '0;
            min_q      <= VAZIO;
            pronto_q   <= 1'b0;
            valid_q    <= 1'b0;
            indice_q   <= '0;
            endereco_q <= '0;
            fim_q      <= 1'b0;
            vazio_q    <= 1'b0;
        end else begin
            pronto_q <= ca_pronto_in;
            if (aa_atualizar_in) begin
                estado_q <= OCIOSO;
                valid_q  <= 1'b0;
                fim_q    <= 1'b0;
                vazio_q  <= 1'b0;
            end else begin
                case (estado_q)
                    OCIOSO: begin
                        fim_q <= 1'b0;
                        if (ca_pronto_in && !pronto_q) begin
                            min_q    <= ca_criterio_geral_in;
                            ptr_q    <= '0;
                            estado_q <= BUSCA;
                        end
                    end
                    BUSCA: begin
                        if (min_q == VAZIO) begin
                            vazio_q  <= 1'b1;
                            fim_q    <= 1'b1;
                            estado_q <= FIM;
                        end else if (acerto) begin
                            valid_q    <= 1'b1;
                            indice_q   <= acerto_idx;
                            endereco_q <= endereco_sel;
                            estado_q   <= EMITE;
                        end else begin
                            ptr_q <= ptr_avanco_d;
                            if (ptr_avanco_d >= PW'(NUM_NA)) begin
                                fim_q    <= 1'b1;
                                estado_q <= FIM;
                            end
                        end
                    end
                    EMITE: begin
                        if (sa_ready_in) begin
                            valid_q <= 1'b0;
                            ptr_q   <= ptr_aceite_d;
`ifdef SELECIONAR_ATIVO_PRIMEIRO_EN
                            fim_q    <= 1'b1;
                            estado_q <= FIM;
`else
                            if (ptr_aceite_d >= PW'(NUM_NA)) begin
                                fim_q    <= 1'b1;
                                estado_q <= FIM;
                            end else begin
                                estado_q <= BUSCA;
                            end
`endif
                        end
                    end
                    FIM: begin
                        fim_q    <= 1'b0;
                        estado_q <= OCIOSO;
                    end
                    default: estado_q <= OCIOSO;
                endcase
            end
        end
    end

    assign sa_valid_o    = valid_q;
    assign sa_indice_o   = indice_q;
    assign sa_endereco_o = endereco_q;
    assign sa_fim_o      = fim_q;
    assign sa_vazio_o    = vazio_q;
endmodule

// File: tb/tb_selecionar_ativo.sv
// tb_selecionar_ativo: directed checks of scan order, latency, stall, empty round,
// abort and asynchronous reset for selecionar_ativo.
module tb_selecionar_ativo;
    localparam int NUM_NA = 8, CW = 5, AW = 8, NP = 4;

    logic                  clk = 1'b0, rst_n = 1'b1, aa = 1'b0, pronto = 1'b0, ready = 1'b0;
    logic [CW-1:0]         min_c = '0;
    logic [NUM_NA-1:0]     ativo = 8'b0010_0100;
    logic [NUM_NA*CW-1:0]  crit;
    logic [NUM_NA*AW-1:0]  ender;
    logic                  valid, fim, vazio;
    logic [2:0]            idx;
    logic [AW-1:0]         addr;
    int                    n_chk = 0, n_ok = 0;

    always #5 clk = ~clk;

    selecionar_ativo #(.NUM_NA(NUM_NA), .CRITERIO_WIDTH(CW), .ADDR_WIDTH(AW), .NUM_PARALELO(NP)) dut (
        .clk(clk), .rst_n(rst_n), .aa_atualizar_in(aa), .ca_pronto_in(pronto),
        .ca_criterio_geral_in(min_c), .na_ativo_in(ativo), .na_criterio_in(crit),
        .na_endereco_in(ender), .sa_ready_in(ready), .sa_valid_o(valid),
        .sa_indice_o(idx), .sa_endereco_o(addr), .sa_fim_o(fim), .sa_vazio_o(vazio)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_round(input logic [CW-1:0] m);
        pronto = 1'b0;
        step();
        min_c  = m;
        pronto = 1'b1;
    endtask

    task automatic wait_fim(input string tag);
        logic seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = fim;
        end
        chk(tag, seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // slot0 also carries criterion 3 but is inactive unless a test enables it
        for (int i = 0; i < NUM_NA; i++) begin
            crit[CW*i +: CW]  = (i == 0 || i == 2 || i == 5) ? CW'(3) : CW'(i + 8);
            ender[AW*i +: AW] = AW'(8'hA0 + i);
        end
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", valid, 0);
        chk("rst_idx", idx, 0);
        chk("rst_addr", addr, 0);
        chk("rst_fim", fim, 0);
        chk("rst_vazio", vazio, 0);
        rst_n = 1'b1;
        step();

        // two tied winners, consumer always ready
        ready = 1'b1;
        new_round(5'd3);
        step(); chk("t1_rise1_valid", valid, 0);
        step(); chk("t1_rise2_valid", valid, 1); chk("t1_idx2", idx, 2); chk("t1_addr2", addr, 8'hA2);
        step(); chk("t1_accept_valid", valid, 0);
`ifdef SELECIONAR_ATIVO_PRIMEIRO_EN
        chk("t1_first_fim", fim, 1);
        step(); chk("t1_first_fim_drop", fim, 0); chk("t1_first_novalid", valid, 0);
`else
        chk("t1_nofim_yet", fim, 0);
        step(); chk("t1_rise4_valid", valid, 1); chk("t1_idx5", idx, 5); chk("t1_addr5", addr, 8'hA5);
        step(); chk("t1_rise5_valid", valid, 0); chk("t1_rise5_fim", fim, 0);
        step(); chk("t1_rise6_fim", fim, 1); chk("t1_vazio", vazio, 0);
        step(); chk("t1_fim_pulse", fim, 0);
`endif

        // empty round
        new_round(5'h1F);
        step(); chk("t2_rise1_fim", fim, 0);
        step(); chk("t2_fim", fim, 1); chk("t2_vazio", vazio, 1); chk("t2_novalid", valid, 0);
        step(); chk("t2_fim_drop", fim, 0); chk("t2_vazio_held", vazio, 1);
        aa = 1'b1;
        step();
        aa = 1'b0;
        chk("t2_vazio_clear", vazio, 0);

        // consumer stalls for five cycles
        ready = 1'b0;
        new_round(5'd3);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_stall_valid", valid, 1);
            chk("t3_stall_idx", idx, 2);
            chk("t3_stall_addr", addr, 8'hA2);
        end
        ready = 1'b1;
        step(); chk("t3_accept", valid, 0);
        wait_fim("t3_fim");

        // abort while emitting, then restart from slot 0
        ready = 1'b0;
        new_round(5'd3);
        step();
        step(); chk("t4_valid", valid, 1); chk("t4_idx2", idx, 2);
        aa = 1'b1;
        step();
        aa = 1'b0;
        chk("t4_abort_valid", valid, 0);
        chk("t4_abort_fim", fim, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_idle_fim", fim, 0);
            chk("t4_idle_valid", valid, 0);
        end
        ativo = 8'b0010_0101;
        new_round(5'd3);
        step();
        step(); chk("t4_restart_valid", valid, 1); chk("t4_restart_idx0", idx, 0); chk("t4_restart_addr", addr, 8'hA0);
        ready = 1'b1;
        wait_fim("t4_fim");

        // asynchronous reset while scanning, winner only in the second window
        ativo = 8'b0010_0000;
        new_round(5'd3);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", valid, 0);
        chk("t5_rst_idx", idx, 0);
        chk("t5_rst_addr", addr, 0);
        chk("t5_rst_fim", fim, 0);
        chk("t5_rst_vazio", vazio, 0);
        pronto = 1'b0;
        step();
        rst_n = 1'b1;
        step(); chk("t5_idle_valid", valid, 0); chk("t5_idle_fim", fim, 0);
        step(); chk("t5_still_idle", valid, 0);
        pronto = 1'b1;
        step();
        step(); chk("t5_rise2_valid", valid, 0);
        step(); chk("t5_rise3_valid", valid, 1); chk("t5_idx5", idx, 5); chk("t5_addr5", addr, 8'hA5);
        wait_fim("t5_fim");

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
